// File: rtl/bcd_dnctr_pkg.sv
// Shared BCD definitions for the down-counter slice.
//   BCD_W   : bits per BCD digit
//   BCD_MAX : largest legal digit value
//   bcd_clamp() : saturates a nibble to BCD_MAX
package bcd_dnctr_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_dn_digit.sv
// One BCD down-counting digit.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (q -> 0)
//   load    : capture d (takes priority over dec)
//   d       : value to load, assumed already in 0..9
//   dec     : decrement this cycle, wrapping 0 -> 9
//   q       : registered digit value
//   is_zero : combinational, 1 when q == 0
module bcd_dn_digit
  import bcd_dnctr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             is_zero
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= d;
    else if (dec)
      q <= (q == '0) ? BCD_MAX : q - 1'b1;
  end

  assign is_zero = (q == '0);

endmodule

// File: rtl/bcd_dnctr.sv
// Cascaded BCD down-counter with optional auto-reload.
//   DIGITS : number of BCD digits (1..4)
//   RELOAD : 1 = reload from the last loaded value on expiry, 0 = one-shot
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (count, reload value, tc -> 0)
//   load   : capture din (nibbles clamped to 9) into count and reload register
//   din    : BCD load value, digit 0 in bits [3:0]
//   en     : decrement request
//   q      : registered BCD count
//   zero   : combinational, 1 when q is all-zero
//   tc     : registered pulse, high while q shows the 0 reached by a decrement
module bcd_dnctr
  import bcd_dnctr_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned RELOAD = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] din,
  input  logic                    en,
  output logic [BCD_W*DIGITS-1:0] q,
  output logic                    zero,
  output logic                    tc
);

  localparam int unsigned W    = BCD_W * DIGITS;
  localparam bit          AUTO = (RELOAD != 0);

  logic [W-1:0]      din_c;
  logic [W-1:0]      rld;
  logic [W-1:0]      dig_d;
  logic [DIGITS-1:0] dig_zero;
  logic [DIGITS:0]   low_zero;
  logic              all_zero;
  logic              count_en;
  logic              reload_fire;
  logic              dig_load;

  always_comb begin
    din_c = '0;
    for (int unsigned k = 0; k < DIGITS; k++)
      din_c[k*BCD_W +: BCD_W] = bcd_clamp(din[k*BCD_W +: BCD_W]);
  end

  // low_zero[k] is set when every digit below k is zero; digit k borrows then.
  always_comb begin
    low_zero    = '0;
    low_zero[0] = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++)
      low_zero[k+1] = low_zero[k] & dig_zero[k];
  end

  assign all_zero    = low_zero[DIGITS];
  assign zero        = all_zero;
  assign count_en    = en & ~load & ~all_zero;
  assign reload_fire = AUTO & en & ~load & all_zero;
  assign dig_load    = load | reload_fire;
  assign dig_d       = load ? din_c : rld;

  always_ff @(posedge clk) begin
    if (rst)
      rld <= '0;
    else if (load)
      rld <= din_c;
  end

  // Only a decrement from exactly 1 produces tc; loads and reloads never do.
  always_ff @(posedge clk) begin
    if (rst)
      tc <= 1'b0;
    else
      tc <= count_en & (q == W'(1));
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_dn_digit u_digit (
      .clk     (clk),
      .rst     (rst),
      .load    (dig_load),
      .d       (dig_d[k*BCD_W +: BCD_W]),
      .dec     (count_en & low_zero[k]),
      .q       (q[k*BCD_W +: BCD_W]),
      .is_zero (dig_zero[k])
    );
  end

endmodule

// File: tb/tb_bcd_dnctr.sv
module tb_bcd_dnctr;

  logic       clk = 1'b0;
  logic       rst, load, en;
  logic [7:0] din;
  logic [7:0] q0, q1;
  logic       z0, z1, tc0, tc1;

  int errors = 0;
  int checks = 0;

  // reference model state: index 0 = one-shot DUT, 1 = auto-reload DUT
  int m_val[2];
  int m_rld[2];
  bit m_tc[2];

  always #5 clk = ~clk;

  bcd_dnctr #(.DIGITS(2), .RELOAD(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .din(din), .en(en),
    .q(q0), .zero(z0), .tc(tc0)
  );

  bcd_dnctr #(.DIGITS(2), .RELOAD(1)) dut1 (
    .clk(clk), .rst(rst), .load(load), .din(din), .en(en),
    .q(q1), .zero(z1), .tc(tc1)
  );

  typedef struct {
    bit         rst;
    bit         load;
    bit         en;
    logic [7:0] din;
    logic [7:0] eq;
    bit         etc;
  } vec_t;

  vec_t vt[$];

  function automatic int clamp_val(logic [7:0] d);
    int lo, hi;
    lo = int'(d[3:0]);
    hi = int'(d[7:4]);
    if (lo > 9) lo = 9;
    if (hi > 9) hi = 9;
    return hi * 10 + lo;
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, return at the falling edge.
  task automatic cyc(bit r, bit l, bit e, logic [7:0] d);
    rst = r; load = l; en = e; din = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_val[k] = 0; m_rld[k] = 0; m_tc[k] = 0;
      end else if (l) begin
        m_val[k] = clamp_val(d); m_rld[k] = m_val[k]; m_tc[k] = 0;
      end else if (e && m_val[k] > 0) begin
        m_tc[k] = (m_val[k] == 1);
        m_val[k]--;
      end else if (e && k == 1) begin
        m_val[k] = m_rld[k]; m_tc[k] = 0;
      end else begin
        m_tc[k] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic exp0(string name, logic [7:0] eq, bit etc);
    check({name, ".q"},    q0,  eq);
    check({name, ".tc"},   {7'd0, tc0}, {7'd0, etc});
    check({name, ".zero"}, {7'd0, z0},  {7'd0, (eq == 8'h00)});
  endtask

  task automatic exp1(string name, logic [7:0] eq, bit etc);
    check({name, ".q"},    q1,  eq);
    check({name, ".tc"},   {7'd0, tc1}, {7'd0, etc});
    check({name, ".zero"}, {7'd0, z1},  {7'd0, (eq == 8'h00)});
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; din = '0;
    @(negedge clk);

    // table: one-shot counter, clamp, borrow, load priority, reset, load of 0
    vt.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 8'hF3, 8'h93, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 8'h3C, 8'h39, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 1'b0});
    vt.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h09, 1'b0});
    vt.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h08, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 8'h12, 8'h12, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b1, 8'h50, 8'h50, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 8'h08, 8'h08, 1'b0});
    vt.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h07, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1'b1, 8'h44, 8'h00, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0});
    vt.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1});
    vt.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 8'h99, 8'h99, 1'b0});
    vt.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 8'h98, 1'b0});

    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].rst, vt[i].load, vt[i].en, vt[i].din);
      exp0($sformatf("vec%0d", i), vt[i].eq, vt[i].etc);
    end

    // full count from 25 to 00, then saturate
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h25);
    exp0("cnt25.load", 8'h25, 1'b0);
    for (int v = 24; v >= 0; v--) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      exp0($sformatf("cnt25.v%0d", v), to_bcd(v), (v == 0));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      exp0($sformatf("cnt25.hold%0d", i), 8'h00, 1'b0);
    end

    // en 1,0,1 from 02; then load while tc is high
    cyc(1'b0, 1'b1, 1'b0, 8'h02);
    cyc(1'b0, 1'b0, 1'b1, 8'h00); exp0("gap.a", 8'h01, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00); exp0("gap.b", 8'h01, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 8'h00); exp0("gap.c", 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 8'h05); exp0("gap.ld", 8'h05, 1'b0);

    // auto-reload: 03,02,01,00,03,...
    cyc(1'b0, 1'b1, 1'b0, 8'h03);
    exp1("rl.load", 8'h03, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      exp1($sformatf("rl.c%0d", i), to_bcd(3 - (i % 4)), (i % 4 == 3));
    end

    // auto-reload with reload value 0 stays at 0, no pulses
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h00);
      exp1($sformatf("rl0.c%0d", i), 8'h00, 1'b0);
    end

    // randomized traffic against the arithmetic model, both variants
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 1) == 0) ? {4'h0, 4'($urandom)} : 8'($urandom);
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 3) != 0), d);
      check($sformatf("rnd%0d.q0", i),  q0, to_bcd(m_val[0]));
      check($sformatf("rnd%0d.tc0", i), {7'd0, tc0}, {7'd0, m_tc[0]});
      check($sformatf("rnd%0d.z0", i),  {7'd0, z0},  {7'd0, (m_val[0] == 0)});
      check($sformatf("rnd%0d.q1", i),  q1, to_bcd(m_val[1]));
      check($sformatf("rnd%0d.tc1", i), {7'd0, tc1}, {7'd0, m_tc[1]});
      check($sformatf("rnd%0d.z1", i),  {7'd0, z1},  {7'd0, (m_val[1] == 0)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_dnctr.md
BCD_DNCTR -- requirements
Module: bcd_dnctr

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of cascaded BCD digits, legal range 1..4.
REQ-002 SHALL have parameter RELOAD, default 0: 1 enables auto-reload on expiry; 0 selects one-shot.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port load, input, 1 bit: capture din into the count and into the reload register.
REQ-006 SHALL have port din, input, 4*DIGITS bits: BCD load value, digit 0 in bits [3:0].
REQ-007 SHALL have port en, input, 1 bit: decrement request for this cycle.
REQ-008 SHALL have port q, output, 4*DIGITS bits: current BCD count, registered.
REQ-009 SHALL have port zero, output, 1 bit: combinational flag, 1 when q is all-zero.
REQ-010 SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.

Function
REQ-011 SHALL give load priority over en; when load=1 in a cycle, en is ignored that cycle.
REQ-012 SHALL clamp any din nibble above 9 to 9 on load, per digit independently.
REQ-013 SHALL store the clamped load value in a reload register, and q SHALL show that value one cycle after the load.
REQ-014 SHALL, when en=1, load=0 and q is non-zero, decrement q by exactly 1 in BCD in one cycle.
REQ-015 SHALL decrement digit 0 on every such cycle, wrapping 0 to 9.
REQ-016 SHALL decrement digit k (k>0) only when all digits below k are 0, wrapping 0 to 9 (borrow ripple).
REQ-017 SHALL keep every digit in 0..9 at all times; no non-BCD value on q.
REQ-018 SHALL set tc=1 for exactly the cycle after the edge on which q goes from 1 to 0 through a decrement.
REQ-019 SHALL, when RELOAD=0, en=1 and q=0, hold q at 0 (saturate) and keep tc=0.
REQ-020 SHALL, when RELOAD=1, en=1 and q=0, load q from the reload register and set tc=0.
REQ-021 SHALL, when RELOAD=1 and the reload register is 0, hold q at 0 with no tc pulses.
REQ-022 SHALL, on a load during the cycle q goes to 0, apply the load; tc SHALL still pulse if the decrement to 0 completed on the previous edge.
REQ-023 SHALL not generate tc from a load of 0.
REQ-024 SHALL add no latency beyond one register stage: en at edge n gives the new q visible after edge n.

Reset
REQ-025 SHALL, when rst=1 at a rising clk edge, set q=0, tc=0 and the reload register to 0.
REQ-026 SHALL give rst priority over load and en.
REQ-027 SHALL abort any count in progress on mid-count reset, with no tc pulse.
REQ-028 SHALL leave zero=1 after reset.

Structure
REQ-029 SHALL place the BCD digit width (4), digit maximum (9) and the clamp function in a shared package.
REQ-030 SHALL instantiate one sub-module per digit, bcd_dn_digit (ports: clk, rst, load, d, dec, q, is_zero), using a generate loop.
REQ-031 SHALL compute the digit borrow chain combinationally from the per-digit is_zero outputs; no extra pipeline registers.
REQ-032 SHALL be implementable in 120-400 lines of RTL in total.

Verification
REQ-033 SHALL cover: reset, then load 0x25 with en held -> q steps 25,24,...,01,00; tc=1 for exactly the one cycle after 00 appears; q then holds 00.
REQ-034 SHALL cover: load 0x10, en=1 -> next q=09 (borrow across digits), then 08.
REQ-035 SHALL cover: load 0xF3 -> q=93 (clamp); load 0x3C -> q=39.
REQ-036 SHALL cover: RELOAD=1, load 0x03, en held -> q sequence 03,02,01,00,03,02,...; tc pulses every 4 cycles, one cycle each.
REQ-037 SHALL cover: load=1 and en=1 together with din=0x50 while q=12 -> q=50; rst during count at q=07 -> q=00 next cycle, tc=0, zero=1.
REQ-038 SHALL cover: en toggled 1,0,1 from q=02 -> q=01, holds 01, then 00 with a single tc pulse.
